crf_regbank: RTL and testbench

CRF_REGBANK -- requirements
Module: crf_regbank

---
 rtl/crf_pkg.sv | 20 ++
 rtl/crf_regbank_if.sv | 36 +++
 rtl/crf_regbank_wr_ctrl.sv | 112 +++++++++++
 rtl/crf_regbank.sv | 172 +++++++++++++++++
 tb/tb_crf_regbank.sv | 530 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crf_pkg.sv
// Shared constants and types for the CRF register bank.
//   CTRL_IDX / STATUS_IDX / IRQ_EN_IDX : word indices of the special registers
//   RESP_OKAY / RESP_SLVERR            : AXI response codes
//   rd_state_e                         : read-channel state
package crf_pkg;

    localparam int unsigned CTRL_IDX   = 0;
    localparam int unsigned STATUS_IDX = 1;
    localparam int unsigned IRQ_EN_IDX = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        RD_RESET,
        RD_IDLE,
        RD_VALID
    } rd_state_e;

endpackage

// File: rtl/crf_regbank_if.sv
// AXI4-Lite slave bundle for the CRF register bank.
//   aw*/w*/b* : write address, write data, write response
//   ar*/r*    : read address, read data
// slave modport is the register bank side, master modport the initiator side.
interface crf_regbank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/crf_regbank_wr_ctrl.sv
// AXI-Lite write-side controller: captures AW and W independently, commits
// once both are held (unless a PL write claims the cycle) and runs the B handshake.
//   aw*/w*/b*   : AXI write channels
//   pl_wr       : PL write strobe, blocks the commit for that cycle
//   commit*     : one-cycle commit strobe with word index, range flag, data, strobes
//   pl_busy     : an AW or W is held but not yet committed
module crf_axil_wr_ctrl
    import crf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int NREG   = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_W-1:0]       awaddr,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [DATA_W/8-1:0]     wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    input  logic                    pl_wr,
    output logic                    commit,
    output logic                    commit_ok,
    output logic [$clog2(NREG)-1:0] commit_idx,
    output logic [DATA_W-1:0]       commit_data,
    output logic [DATA_W/8-1:0]     commit_strb,
    output logic                    pl_busy
);
    localparam int IDX_W  = $clog2(NREG);
    localparam int WIDX_W = ADDR_W - 2;

    logic                en_q, en_d;
    logic                aw_held_q, aw_held_d;
    logic [WIDX_W-1:0]   aw_idx_q, aw_idx_d;
    logic                w_held_q, w_held_d;
    logic [DATA_W-1:0]   w_data_q, w_data_d;
    logic [DATA_W/8-1:0] w_strb_q, w_strb_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                unused_awaddr_lsb;

    assign unused_awaddr_lsb = ^awaddr[1:0];

    // en_q keeps the ready outputs low through reset and the first edge after it
    assign awready     = en_q & ~aw_held_q & ~bvalid_q;
    assign wready      = en_q & ~w_held_q & ~bvalid_q;
    assign bvalid      = bvalid_q;
    assign bresp       = bresp_q;
    assign commit      = aw_held_q & w_held_q & ~pl_wr;
    assign commit_ok   = 32'(aw_idx_q) < 32'(NREG);
    assign commit_idx  = aw_idx_q[IDX_W-1:0];
    assign commit_data = w_data_q;
    assign commit_strb = w_strb_q;
    assign pl_busy     = aw_held_q | w_held_q;

    always_comb begin
        en_d      = 1'b1;
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        if (awvalid && awready) begin
            aw_held_d = 1'b1;
            aw_idx_d  = awaddr[ADDR_W-1:2];
        end
        if (wvalid && wready) begin
            w_held_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = commit_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q      <= 1'b0;
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            en_q      <= en_d;
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end
endmodule

// File: rtl/crf_regbank.sv
// CRF control/status register bank with an AXI4-Lite slave and a PL write port.
//   reg0 CTRL (bit0 is a self-clearing start bit), reg1 STATUS (W1C, sticky
//   sts_set), reg2 IRQ_EN, reg3..NREG-1 plain RW.
//   clk, rstn (async active-low) ; s_axi : AXI-Lite slave bundle
//   pl_wr/pl_idx/pl_wdata/pl_wmask : bit-masked PL write, wins over AXI
//   sts_set : per-bit STATUS set pulses ; pl_busy : AXI write held, not committed
//   start_pulse : one-cycle strobe after CTRL bit0 written 1 ; irq : |(STATUS & IRQ_EN)
//   regs_flat : all registers, reg i at [i*DATA_W +: DATA_W]
module crf_regbank
    import crf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int NREG   = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    crf_regbank_if.slave            s_axi,
    input  logic                    pl_wr,
    input  logic [$clog2(NREG)-1:0] pl_idx,
    input  logic [DATA_W-1:0]       pl_wdata,
    input  logic [DATA_W-1:0]       pl_wmask,
    input  logic [DATA_W-1:0]       sts_set,
    output logic                    pl_busy,
    output logic                    start_pulse,
    output logic                    irq,
    output logic [NREG*DATA_W-1:0]  regs_flat
);
    localparam int IDX_W  = $clog2(NREG);
    localparam int STRB_W = DATA_W / 8;

    logic                commit, commit_ok;
    logic [IDX_W-1:0]    commit_idx;
    logic [DATA_W-1:0]   commit_data;
    logic [STRB_W-1:0]   commit_strb;

    crf_axil_wr_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_wr_ctrl (
        .clk         (clk),
        .rstn        (rstn),
        .awvalid     (s_axi.awvalid),
        .awready     (s_axi.awready),
        .awaddr      (s_axi.awaddr),
        .wvalid      (s_axi.wvalid),
        .wready      (s_axi.wready),
        .wdata       (s_axi.wdata),
        .wstrb       (s_axi.wstrb),
        .bvalid      (s_axi.bvalid),
        .bready      (s_axi.bready),
        .bresp       (s_axi.bresp),
        .pl_wr       (pl_wr),
        .commit      (commit),
        .commit_ok   (commit_ok),
        .commit_idx  (commit_idx),
        .commit_data (commit_data),
        .commit_strb (commit_strb),
        .pl_busy     (pl_busy)
    );

    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];
    logic [DATA_W-1:0]   wmask, w1c_clear;
    logic                start_pulse_q, start_pulse_d;
    rd_state_e           rd_state_q, rd_state_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [ADDR_W-3:0]   rd_widx;
    logic                rd_ok;
    logic                unused_araddr_lsb;

    // ---------------- register update ----------------
    always_comb begin
        wmask = '0;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            wmask[b*8 +: 8] = {8{commit_strb[b]}};
        end
        w1c_clear = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end

        // commit is already gated by pl_wr inside the write controller
        if (pl_wr) begin
            if (32'(pl_idx) < 32'(NREG)) begin
                regs_d[pl_idx] = (regs_q[pl_idx] & ~pl_wmask) | (pl_wdata & pl_wmask);
            end
        end else if (commit && commit_ok) begin
            if (32'(commit_idx) == STATUS_IDX) begin
                w1c_clear = commit_data & wmask;
            end else begin
                regs_d[commit_idx] = (regs_q[commit_idx] & ~wmask) | (commit_data & wmask);
            end
        end

        // clear first, then set, so a same-cycle set survives the W1C
        regs_d[STATUS_IDX] = (regs_d[STATUS_IDX] & ~w1c_clear) | sts_set;
        regs_d[CTRL_IDX][0] = 1'b0;

        start_pulse_d = commit && commit_ok && (32'(commit_idx) == CTRL_IDX)
                        && commit_strb[0] && commit_data[0];
    end

    assign start_pulse = start_pulse_q;
    assign irq         = |(regs_q[STATUS_IDX] & regs_q[IRQ_EN_IDX]);

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    // ---------------- read channel ----------------
    assign rd_widx           = s_axi.araddr[ADDR_W-1:2];
    assign rd_ok             = 32'(rd_widx) < 32'(NREG);
    assign unused_araddr_lsb = ^s_axi.araddr[1:0];

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_RESET: rd_state_d = RD_IDLE;
            RD_IDLE: begin
                if (s_axi.arvalid) begin
                    rd_state_d = RD_VALID;
                    if (rd_ok) begin
                        rdata_d = regs_q[rd_widx[IDX_W-1:0]];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            RD_VALID: begin
                if (s_axi.rready) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    assign s_axi.arready = (rd_state_q == RD_IDLE);
    assign s_axi.rvalid  = (rd_state_q == RD_VALID);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            start_pulse_q <= 1'b0;
            rd_state_q    <= RD_RESET;
            rdata_q       <= '0;
            rresp_q       <= RESP_OKAY;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            start_pulse_q <= start_pulse_d;
            rd_state_q    <= rd_state_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
        end
    end
endmodule

// File: tb/tb_crf_regbank.sv
// Self-checking bench for crf_regbank: directed scenarios plus randomized
// AXI/PL traffic checked against a register-level reference model.
module tb_crf_regbank;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int NREG   = 8;
    localparam int IDX_W  = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    crf_regbank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) axi ();

    logic                   pl_wr;
    logic [IDX_W-1:0]       pl_idx;
    logic [31:0]            pl_wdata, pl_wmask, sts_set;
    logic                   pl_busy, start_pulse, irq;
    logic [NREG*DATA_W-1:0] regs_flat;

    crf_regbank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .s_axi       (axi),
        .pl_wr       (pl_wr),
        .pl_idx      (pl_idx),
        .pl_wdata    (pl_wdata),
        .pl_wmask    (pl_wmask),
        .sts_set     (sts_set),
        .pl_busy     (pl_busy),
        .start_pulse (start_pulse),
        .irq         (irq),
        .regs_flat   (regs_flat)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_regs [NREG];

    function automatic void m_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
    endfunction

    function automatic logic [NREG*32-1:0] m_flat();
        logic [NREG*32-1:0] f;
        for (int i = 0; i < NREG; i++) f[i*32 +: 32] = m_regs[i];
        return f;
    endfunction

    function automatic logic m_irq();
        return (m_regs[1] & m_regs[2]) != 32'h0;
    endfunction

    // returns expected bresp
    function automatic logic [1:0] m_axi_write(input logic [7:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx;
        logic [31:0] bm;
        idx = int'(addr) / 4;
        bm  = 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) bm[8*b +: 8] = 8'hFF;
        if (idx >= NREG) return 2'b10;
        if (idx == 1) m_regs[1] = m_regs[1] & ~(data & bm);
        else          m_regs[idx] = (m_regs[idx] & ~bm) | (data & bm);
        m_regs[0][0] = 1'b0;
        return 2'b00;
    endfunction

    function automatic void m_pl_write(input int idx, input logic [31:0] data, input logic [31:0] mask);
        m_regs[idx] = (m_regs[idx] & ~mask) | (data & mask);
        m_regs[0][0] = 1'b0;
    endfunction

    function automatic void m_sts(input logic [31:0] s);
        m_regs[1] = m_regs[1] | s;
    endfunction

    // ---------------- drivers ----------------
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output logic sp_b, output logic sp_next);
        bit aw_done = 0;
        bit w_done  = 0;
        bit seen    = 0;
        bit aw_hs, w_hs;
        int cyc = 0;
        axi.bready = 1'b1;
        axi.awaddr = addr;
        axi.wdata  = data;
        axi.wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            axi.awvalid = !aw_done && (cyc >= aw_dly);
            axi.wvalid  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
            cyc++;
        end
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        resp = 2'bxx; sp_b = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (axi.bvalid) begin
                seen = 1; resp = axi.bresp; sp_b = start_pulse;
            end else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (!(aw_done && w_done && seen)) begin
            errors++;
            $display("FAIL axi_write_timeout addr=%h aw=%0d w=%0d b=%0d required 1 1 1",
                     addr, aw_done, w_done, seen);
        end
        @(posedge clk); #1;
        sp_next = start_pulse;
        axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, input int rdy_dly,
                            output logic [31:0] data, output logic [1:0] resp,
                            output logic lat_ok, output logic stable);
        bit hs = 0;
        int cyc = 0;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b0;
        while (!hs && cyc < 20) begin
            @(negedge clk);
            hs = axi.arready;
            @(posedge clk); #1;
            cyc++;
        end
        axi.arvalid = 1'b0;
        lat_ok = hs && axi.rvalid;
        data   = axi.rdata;
        resp   = axi.rresp;
        stable = 1'b1;
        for (int k = 0; k < rdy_dly; k++) begin
            @(posedge clk); #1;
            if (!axi.rvalid || axi.rdata !== data || axi.rresp !== resp) stable = 1'b0;
        end
        axi.rready = 1'b1;
        @(posedge clk); #1;
        axi.rready = 1'b0;
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL axi_read_timeout addr=%h arready never seen", addr);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({axi.awready, axi.wready, axi.bvalid, axi.rvalid, axi.arready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake got aw/w/b/r/ar=%b required 00000",
                     {axi.awready, axi.wready, axi.bvalid, axi.rvalid, axi.arready});
        end
        checks++;
        if ({start_pulse, pl_busy, irq} !== 3'b0 || axi.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got sp/busy/irq=%b rdata=%h required 000 0",
                     {start_pulse, pl_busy, irq}, axi.rdata);
        end
        checks++;
        if (regs_flat !== m_flat()) begin
            errors++;
            $display("FAIL reset_regs got %h required %h", regs_flat, m_flat());
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({axi.arready, axi.awready, axi.wready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready got ar/aw/w=%b required 111",
                     {axi.arready, axi.awready, axi.wready});
        end
    endtask

    task automatic test_write_latency();
        logic [1:0] er;
        axi.awaddr = 8'h0C; axi.awvalid = 1'b1;
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        checks++;
        if (axi.awready !== 1'b0 || pl_busy !== 1'b1) begin
            errors++;
            $display("FAIL aw_held got awready=%b pl_busy=%b required 0 1", axi.awready, pl_busy);
        end
        repeat (2) @(posedge clk);
        #1;
        axi.wdata = 32'hA5A5A5A5; axi.wstrb = 4'h3; axi.wvalid = 1'b1;
        @(posedge clk); #1;
        axi.wvalid = 1'b0;
        checks++;
        if (axi.bvalid !== 1'b0) begin
            errors++;
            $display("FAIL bvalid_early got %b required 0", axi.bvalid);
        end
        @(posedge clk); #1;
        er = m_axi_write(8'h0C, 32'hA5A5A5A5, 4'h3);
        checks++;
        if (axi.bvalid !== 1'b1 || axi.bresp !== er || pl_busy !== 1'b0) begin
            errors++;
            $display("FAIL commit_b got bvalid=%b bresp=%b busy=%b required 1 %b 0",
                     axi.bvalid, axi.bresp, pl_busy, er);
        end
        checks++;
        if (regs_flat[3*32 +: 32] !== 32'h0000A5A5 || regs_flat !== m_flat()) begin
            errors++;
            $display("FAIL reg3_strb got %h required 0000a5a5", regs_flat[3*32 +: 32]);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (axi.bvalid !== 1'b1 || axi.awready !== 1'b0 || axi.wready !== 1'b0) begin
            errors++;
            $display("FAIL b_hold got bvalid=%b awready=%b wready=%b required 1 0 0",
                     axi.bvalid, axi.awready, axi.wready);
        end
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        checks++;
        if (axi.bvalid !== 1'b0 || axi.awready !== 1'b1) begin
            errors++;
            $display("FAIL b_release got bvalid=%b awready=%b required 0 1", axi.bvalid, axi.awready);
        end
    endtask

    task automatic test_random_rw();
        logic [1:0] er, gr;
        logic sp_b, sp_n, lat, stab;
        logic [31:0] gd, ed, d;
        logic [3:0] s;
        int idx;
        for (int n = 0; n < 40; n++) begin
            idx = int'($urandom_range(0, 9));
            d   = $urandom;
            s   = 4'($urandom);
            er  = m_axi_write(8'(idx * 4), d, s);
            axi_write(8'(idx * 4), d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      gr, sp_b, sp_n);
            checks++;
            if (gr !== er || regs_flat !== m_flat()) begin
                errors++;
                $display("FAIL rand_write idx=%0d got resp=%b regs=%h required %b %h",
                         idx, gr, regs_flat, er, m_flat());
            end
            checks++;
            if (sp_b !== (idx == 0 && s[0] && d[0]) || sp_n !== 1'b0 || irq !== m_irq()) begin
                errors++;
                $display("FAIL rand_side idx=%0d got sp=%b%b irq=%b required %b0 %b",
                         idx, sp_b, sp_n, irq, (idx == 0 && s[0] && d[0]), m_irq());
            end
        end
        for (int n = 0; n < 20; n++) begin
            idx = int'($urandom_range(0, 9));
            ed  = (idx < NREG) ? m_regs[idx] : 32'h0;
            er  = (idx < NREG) ? 2'b00 : 2'b10;
            axi_read(8'(idx * 4), int'($urandom_range(0, 2)), gd, gr, lat, stab);
            checks++;
            if (gd !== ed || gr !== er || lat !== 1'b1 || stab !== 1'b1) begin
                errors++;
                $display("FAIL rand_read idx=%0d got data=%h resp=%b lat=%b stable=%b required %h %b 1 1",
                         idx, gd, gr, lat, stab, ed, er);
            end
        end
    endtask

    task automatic test_pl_sts();
        int idx;
        for (int n = 0; n < 16; n++) begin
            idx      = int'($urandom_range(0, NREG - 1));
            pl_wr    = 1'($urandom);
            pl_idx   = IDX_W'(idx);
            pl_wdata = $urandom;
            pl_wmask = $urandom;
            sts_set  = ($urandom_range(0, 1) == 1) ? 32'(1 << $urandom_range(0, 31)) : 32'h0;
            if (pl_wr) m_pl_write(idx, pl_wdata, pl_wmask);
            m_sts(sts_set);
            @(posedge clk); #1;
            pl_wr = 1'b0; sts_set = 32'h0;
            checks++;
            if (regs_flat !== m_flat() || irq !== m_irq()) begin
                errors++;
                $display("FAIL pl_sts n=%0d got regs=%h irq=%b required %h %b",
                         n, regs_flat, irq, m_flat(), m_irq());
            end
        end
    endtask

    task automatic test_status_irq();
        logic [1:0] gr, er;
        logic sp_b, sp_n;
        er = m_axi_write(8'h04, 32'hFFFFFFFF, 4'hF);
        axi_write(8'h04, 32'hFFFFFFFF, 4'hF, 0, 0, gr, sp_b, sp_n);
        er = m_axi_write(8'h08, 32'h4, 4'hF);
        axi_write(8'h08, 32'h4, 4'hF, 0, 0, gr, sp_b, sp_n);
        sts_set = 32'h4;
        @(posedge clk); #1;
        sts_set = 32'h0;
        m_sts(32'h4);
        checks++;
        if (irq !== 1'b1 || regs_flat !== m_flat()) begin
            errors++;
            $display("FAIL irq_set got irq=%b status=%h required 1 %h", irq, regs_flat[63:32], m_regs[1]);
        end
        // W1C of bit2 commits on the same edge that sts_set pulses bit2
        axi.awaddr = 8'h04; axi.wdata = 32'h4; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        sts_set = 32'h4;
        @(posedge clk); #1;
        sts_set = 32'h0;
        er = m_axi_write(8'h04, 32'h4, 4'hF);
        m_sts(32'h4);
        checks++;
        if (axi.bvalid !== 1'b1 || regs_flat[32+2] !== 1'b1 || regs_flat !== m_flat() || irq !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear got bvalid=%b status=%h irq=%b required 1 %h 1",
                     axi.bvalid, regs_flat[63:32], irq, m_regs[1]);
        end
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        er = m_axi_write(8'h04, 32'h4, 4'hF);
        axi_write(8'h04, 32'h4, 4'hF, 1, 0, gr, sp_b, sp_n);
        checks++;
        if (irq !== 1'b0 || gr !== er || regs_flat !== m_flat()) begin
            errors++;
            $display("FAIL w1c_alone got irq=%b resp=%b status=%h required 0 %b %h",
                     irq, gr, regs_flat[63:32], er, m_regs[1]);
        end
    endtask

    task automatic test_pl_priority();
        logic [1:0] er;
        axi.awaddr = 8'h0C; axi.wdata = 32'h1234_5678; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        pl_wr = 1'b1; pl_idx = 3'd3; pl_wdata = 32'hCAFE_0001; pl_wmask = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        pl_wr = 1'b0;
        m_pl_write(3, 32'hCAFE_0001, 32'hFFFF_FFFF);
        checks++;
        if (regs_flat[3*32 +: 32] !== 32'hCAFE_0001 || axi.bvalid !== 1'b0 || pl_busy !== 1'b1) begin
            errors++;
            $display("FAIL pl_first got reg3=%h bvalid=%b busy=%b required cafe0001 0 1",
                     regs_flat[3*32 +: 32], axi.bvalid, pl_busy);
        end
        @(posedge clk); #1;
        er = m_axi_write(8'h0C, 32'h1234_5678, 4'hF);
        checks++;
        if (regs_flat !== m_flat() || axi.bvalid !== 1'b1 || axi.bresp !== er) begin
            errors++;
            $display("FAIL axi_after_pl got reg3=%h bvalid=%b required %h 1",
                     regs_flat[3*32 +: 32], axi.bvalid, m_regs[3]);
        end
        axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.bready = 1'b0;
    endtask

    task automatic test_concurrent_read();
        logic [31:0] old_v;
        logic [1:0] er;
        old_v = m_regs[4];
        axi.awaddr = 8'h10; axi.wdata = ~old_v; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        axi.araddr = 8'h10; axi.arvalid = 1'b1;
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        er = m_axi_write(8'h10, ~old_v, 4'hF);
        checks++;
        if (axi.rvalid !== 1'b1 || axi.rdata !== old_v || regs_flat !== m_flat()) begin
            errors++;
            $display("FAIL read_on_commit got rvalid=%b rdata=%h reg4=%h required 1 %h %h",
                     axi.rvalid, axi.rdata, regs_flat[4*32 +: 32], old_v, m_regs[4]);
        end
        axi.rready = 1'b1; axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.rready = 1'b0; axi.bready = 1'b0;
    endtask

    task automatic test_oob();
        logic [31:0] gd;
        logic [1:0] gr, er;
        logic lat, stab, sp_b, sp_n;
        axi_read(8'h40, 1, gd, gr, lat, stab);
        checks++;
        if (gd !== 32'h0 || gr !== 2'b10 || lat !== 1'b1) begin
            errors++;
            $display("FAIL oob_read got data=%h resp=%b lat=%b required 0 10 1", gd, gr, lat);
        end
        er = m_axi_write(8'h40, 32'hFFFF_FFFF, 4'hF);
        axi_write(8'h40, 32'hFFFF_FFFF, 4'hF, 0, 2, gr, sp_b, sp_n);
        checks++;
        if (gr !== er || gr !== 2'b10 || regs_flat !== m_flat()) begin
            errors++;
            $display("FAIL oob_write got resp=%b regs=%h required 10 %h", gr, regs_flat, m_flat());
        end
    endtask

    task automatic test_start_pulse();
        logic [31:0] gd;
        logic [1:0] gr, er;
        logic lat, stab, sp_b, sp_n;
        er = m_axi_write(8'h00, 32'h1, 4'hF);
        axi_write(8'h00, 32'h1, 4'hF, 0, 0, gr, sp_b, sp_n);
        checks++;
        if (sp_b !== 1'b1 || sp_n !== 1'b0) begin
            errors++;
            $display("FAIL start_pulse got cycle1=%b cycle2=%b required 1 0", sp_b, sp_n);
        end
        axi_read(8'h00, 0, gd, gr, lat, stab);
        checks++;
        if (gd !== m_regs[0] || gd[0] !== 1'b0) begin
            errors++;
            $display("FAIL ctrl_bit0_read got %h required %h", gd, m_regs[0]);
        end
        er = m_axi_write(8'h00, 32'hFFFF_FFFF, 4'hE);
        axi_write(8'h00, 32'hFFFF_FFFF, 4'hE, 0, 0, gr, sp_b, sp_n);
        checks++;
        if (sp_b !== 1'b0 || regs_flat !== m_flat()) begin
            errors++;
            $display("FAIL start_no_strb got sp=%b ctrl=%h required 0 %h", sp_b, regs_flat[31:0], m_regs[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] er;
        axi.awaddr = 8'h14; axi.wdata = 32'h5555_AAAA; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        m_reset();
        checks++;
        if (axi.bvalid !== 1'b0 || regs_flat !== m_flat() || start_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_b got bvalid=%b regs=%h required 0 0", axi.bvalid, regs_flat);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        // AW captured, then reset: the later W alone must not commit
        axi.awaddr = 8'h18; axi.awvalid = 1'b1;
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        rstn = 1'b0;
        #1;
        checks++;
        if (pl_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b required 0", pl_busy);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        axi.wdata = 32'h0BAD_F00D; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        @(posedge clk); #1;
        axi.wvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (axi.bvalid !== 1'b0 || regs_flat !== m_flat() || pl_busy !== 1'b1) begin
            errors++;
            $display("FAIL stale_aw got bvalid=%b busy=%b regs=%h required 0 1 %h",
                     axi.bvalid, pl_busy, regs_flat, m_flat());
        end
        axi.awaddr = 8'h18; axi.awvalid = 1'b1; axi.bready = 1'b1;
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        @(posedge clk); #1;
        er = m_axi_write(8'h18, 32'h0BAD_F00D, 4'hF);
        checks++;
        if (axi.bvalid !== 1'b1 || axi.bresp !== er || regs_flat !== m_flat()) begin
            errors++;
            $display("FAIL w_before_aw got bvalid=%b resp=%b reg6=%h required 1 %b %h",
                     axi.bvalid, axi.bresp, regs_flat[6*32 +: 32], er, m_regs[6]);
        end
        @(posedge clk); #1;
        axi.bready = 1'b0;
    endtask

    initial begin
        axi.awvalid = 1'b0; axi.awaddr = '0; axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0;
        axi.bready  = 1'b0; axi.arvalid = 1'b0; axi.araddr = '0; axi.rready = 1'b0;
        pl_wr = 1'b0; pl_idx = '0; pl_wdata = '0; pl_wmask = '0; sts_set = '0;
        m_reset();
        test_reset();
        test_write_latency();
        test_random_rw();
        test_pl_sts();
        test_status_irq();
        test_pl_priority();
        test_concurrent_read();
        test_oob();
        test_start_pulse();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
